dircc_mailbox_writer: RTL and testbench
=======================================

Name: dircc_mailbox_writer

Overview:
- Ingress stage directly upstream of a node's processing memory.
- Receives 16-bit packet beats from the node's network interface and writes them into a ring of fixed-size mailbox slots in the memory's 16-bit port (15-bit word address).
- Tracks slot occupancy and raises an interrupt to the node CPU, which frees slots in order through a release pulse.

Parameters:
- BASE_ADDR, 15'h4000, 16-bit word address of slot 0 in the processing memory.
- NUM_SLOTS, 8, number of mailbox slots; power of 2, range 2..64.
- SLOT_WORDS, 64, 16-bit words per slot including the header; power of 2, range 4..1024.
- Constraint: BASE_ADDR + NUM_SLOTS*SLOT_WORDS <= 20480. Checked at elaboration; fatal on violation.

Ports:
- clk  in  1  single system clock
- reset  in  1  synchronous, active-high reset
- in_data  in  16  packet beat data
- in_valid  in  1  beat valid
- in_sop  in  1  first beat of packet
- in_eop  in  1  last beat of packet
- in_ready  out  1  beat accepted when in_valid & in_ready
- mem_address  out  15  word address to memory port 2
- mem_chipselect  out  1  asserted with mem_write
- mem_write  out  1  write strobe, one word per cycle
- mem_writedata  out  16  write data
- mem_byteenable  out  2  constant 2'b11
- mem_clken  out  1  constant 1
- release  in  1  CPU pulse: oldest committed slot consumed
- wr_slot  out  log2(NUM_SLOTS)  slot currently being filled
- rd_slot  out  log2(NUM_SLOTS)  oldest committed slot
- slots_used  out  log2(NUM_SLOTS)+1  committed, unreleased slots
- drop_count  out  16  packets dropped because the ring was full; saturates at 16'hFFFF
- irq  out  1  registered, equals (slots_used != 0)

Behaviour:
- Reset values: state IDLE; wr_slot, rd_slot, slots_used, drop_count all 0; irq 0; mem_write/mem_chipselect 0.
- Reset mid-packet: partial payload stays in memory; no header is written and the slot is not committed.
- Slot layout, with slot_base = BASE_ADDR + slot*SLOT_WORDS:
  - word 0 is the header: bit15 = truncated flag, bits14:0 = payload word count.
  - words 1..SLOT_WORDS-1 hold payload.
- Memory writes are combinational from the accepted beat (zero latency). mem_address, mem_writedata and mem_write are valid in the same cycle as in_valid & in_ready. The memory accepts one write per cycle with no backpressure.
- FSM states IDLE, PAYLOAD, HEADER, DROP. in_ready = 1 in every state except HEADER.
- IDLE:
  - Beat without in_sop: discarded, no write, no count.
  - in_sop with slots_used < NUM_SLOTS: write to word 1, offset := 2, count := 1. Go to HEADER if in_eop, else PAYLOAD.
  - in_sop with slots_used == NUM_SLOTS: no write; drop_count++. Go to DROP unless in_eop.
- PAYLOAD:
  - Each accepted beat writes at the current offset, then offset++ and count++.
  - Once offset == SLOT_WORDS, further beats are not written and the truncated flag is set; count saturates at SLOT_WORDS-1.
  - in_sop inside PAYLOAD is treated as ordinary data.
  - Go to HEADER on in_eop.
- HEADER (exactly 1 cycle):
  - Write the header word at slot_base.
  - wr_slot increments, wrapping NUM_SLOTS-1 -> 0.
  - slots_used increments. Go to IDLE.
- DROP: accept and discard beats until in_eop, then go to IDLE.
- release:
  - If slots_used > 0, rd_slot increments with wrap and slots_used decrements.
  - If slots_used == 0, ignored.
  - release in the same cycle as a HEADER commit: both pointers advance and slots_used is unchanged.
  - release never frees the slot currently being filled.
- irq updates one cycle after slots_used changes.

Decomposition:
- Package dircc_mailbox_pkg:
  - FSM state enum.
  - Header field positions: HDR_TRUNC_BIT = 15, HDR_LEN_MSB = 14.
  - MEM_ADDR_W = 15, MEM_DATA_W = 16.
- Sub-module dircc_slot_ring: wr/rd pointers and occupancy counter with commit/release inputs and full/empty outputs. Reused later for the egress side.

Test Plan:
- 3-beat packet 0xA001, 0xA002, 0xA003 (sop on first, eop on third) -> writes 0x4001..0x4003, then header 0x0003 at 0x4000. wr_slot = 1, slots_used = 1; irq = 1 one cycle later.
- Single beat with sop & eop, data 0x1234 -> 0x1234 at 0x4001, header 0x0001 at 0x4000, exactly 2 write cycles.
- 70-beat packet into slot 1 -> payload at 0x4041..0x407F (63 words), header 0x803F at 0x4040, beats 64..70 unwritten, in_ready held 1 throughout.
- Fill all 8 slots, then send 2 more packets -> no memory writes for either, drop_count = 2, slots_used = 8. After one release, the next packet lands in slot 0 at 0x4000.
- release on the same cycle as a HEADER commit with slots_used = 3 -> slots_used stays 3, rd_slot and wr_slot each +1. release with slots_used = 0 -> no change.
- Assert reset during beat 2 of a 4-beat packet -> all outputs return to reset values, header at 0x4000 is not written, and the next packet restarts in slot 0.

Source files
------------

// File: rtl/dircc_mailbox_pkg.sv
// Shared types and constants for the mailbox ingress path.
// Header layout: one flag bit above a 15-bit payload word count.
package dircc_mailbox_pkg;

    localparam int unsigned MEM_ADDR_W    = 15;
    localparam int unsigned MEM_DATA_W    = 16;
    localparam int unsigned HDR_TRUNC_BIT = 15;
    localparam int unsigned HDR_LEN_MSB   = 14;
    localparam int unsigned HDR_LEN_W     = HDR_LEN_MSB + 1;
    localparam int unsigned ADDR_LIMIT    = 20480;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PAYLOAD,
        ST_HEADER,
        ST_DROP
    } mbx_state_t;

    typedef struct packed {
        logic                 trunc;
        logic [HDR_LEN_W-1:0] len;
    } mbx_hdr_t;

endpackage

// File: rtl/dircc_slot_ring.sv
// Write/read pointers and occupancy for a power-of-2 ring of slots.
// Commit and release in the same cycle advance both pointers with no net count change.
module dircc_slot_ring #(
    parameter  int unsigned NUM_SLOTS = 8,
    localparam int unsigned PTR_W     = $clog2(NUM_SLOTS),
    localparam int unsigned CNT_W     = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             commit,
    input  logic             release_pulse,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [PTR_W-1:0] rd_ptr,
    output logic [CNT_W-1:0] count,
    output logic             full_c,
    output logic             empty_c
);

    logic do_release;
    logic do_commit;

    assign full_c  = (count == CNT_W'(NUM_SLOTS));
    assign empty_c = (count == '0);

    // A release on an empty ring is ignored; a commit on a full ring needs a matching release.
    always_comb begin
        do_release = release_pulse && !empty_c;
        do_commit  = commit && (!full_c || do_release);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_commit)  wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_release) rd_ptr <= rd_ptr + PTR_W'(1);
            if (do_commit && !do_release)
                count <= count + CNT_W'(1);
            else if (!do_commit && do_release)
                count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/dircc_mailbox_writer.sv
// Packet ingress: writes beats into a ring of fixed-size mailbox slots, then a length header.
// Memory writes are combinational from the accepted beat; the header goes out in a dedicated cycle.
module dircc_mailbox_writer
    import dircc_mailbox_pkg::*;
#(
    parameter  int unsigned BASE_ADDR  = 32'h4000,
    parameter  int unsigned NUM_SLOTS  = 8,
    parameter  int unsigned SLOT_WORDS = 64,
    localparam int unsigned PTR_W      = $clog2(NUM_SLOTS),
    localparam int unsigned CNT_W      = PTR_W + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [MEM_DATA_W-1:0] in_data,
    input  logic                  in_valid,
    input  logic                  in_sop,
    input  logic                  in_eop,
    output logic                  in_ready,
    output logic [MEM_ADDR_W-1:0] mem_address,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic [MEM_DATA_W-1:0] mem_writedata,
    output logic [1:0]            mem_byteenable,
    output logic                  mem_clken,
    input  logic                  release_pulse,
    output logic [PTR_W-1:0]      wr_slot,
    output logic [PTR_W-1:0]      rd_slot,
    output logic [CNT_W-1:0]      slots_used,
    output logic [15:0]           drop_count,
    output logic                  irq
);

    localparam int unsigned SLOT_SHIFT = $clog2(SLOT_WORDS);
    localparam int unsigned OFF_W      = SLOT_SHIFT + 1;

    if (BASE_ADDR + NUM_SLOTS * SLOT_WORDS > ADDR_LIMIT) begin : g_bad_window
        $fatal(1, "dircc_mailbox_writer: slot ring exceeds the memory window");
    end
    if (NUM_SLOTS < 2 || NUM_SLOTS > 64 || (NUM_SLOTS & (NUM_SLOTS - 1)) != 0) begin : g_bad_slots
        $fatal(1, "dircc_mailbox_writer: NUM_SLOTS must be a power of 2 in 2..64");
    end
    if (SLOT_WORDS < 4 || SLOT_WORDS > 1024 || (SLOT_WORDS & (SLOT_WORDS - 1)) != 0) begin : g_bad_words
        $fatal(1, "dircc_mailbox_writer: SLOT_WORDS must be a power of 2 in 4..1024");
    end

    mbx_state_t            state;
    logic [OFF_W-1:0]      offset;
    logic                  trunc;
    logic                  ring_full;
    logic                  ring_empty;
    logic                  slot_at_end;
    logic [MEM_ADDR_W-1:0] slot_base;
    mbx_hdr_t              hdr;

    dircc_slot_ring #(
        .NUM_SLOTS (NUM_SLOTS)
    ) u_ring (
        .clk           (clk),
        .reset         (reset),
        .commit        (state == ST_HEADER),
        .release_pulse (release_pulse),
        .wr_ptr        (wr_slot),
        .rd_ptr        (rd_slot),
        .count         (slots_used),
        .full_c        (ring_full),
        .empty_c       (ring_empty)
    );

    assign in_ready       = (state != ST_HEADER);
    assign mem_chipselect = mem_write;
    assign mem_byteenable = 2'b11;
    assign mem_clken      = 1'b1;
    assign slot_at_end    = (offset == OFF_W'(SLOT_WORDS));
    assign slot_base      = MEM_ADDR_W'(BASE_ADDR) + (MEM_ADDR_W'(wr_slot) << SLOT_SHIFT);

    // offset is the next payload word; the count is always offset-1, capped at SLOT_WORDS-1.
    always_comb begin
        hdr.trunc = trunc;
        hdr.len   = HDR_LEN_W'(offset - OFF_W'(1));
    end

    always_comb begin
        mem_write     = 1'b0;
        mem_address   = slot_base + MEM_ADDR_W'(offset);
        mem_writedata = in_data;
        case (state)
            ST_IDLE: begin
                if (in_valid && in_sop && !ring_full) begin
                    mem_write   = 1'b1;
                    mem_address = slot_base + MEM_ADDR_W'(1);
                end
            end
            ST_PAYLOAD: mem_write = in_valid && !slot_at_end;
            ST_HEADER: begin
                mem_write     = 1'b1;
                mem_address   = slot_base;
                mem_writedata = hdr;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            offset     <= '0;
            trunc      <= 1'b0;
            drop_count <= '0;
            irq        <= 1'b0;
        end else begin
            irq <= !ring_empty;
            case (state)
                ST_IDLE: begin
                    if (in_valid && in_sop) begin
                        if (!ring_full) begin
                            offset <= OFF_W'(2);
                            trunc  <= 1'b0;
                            state  <= in_eop ? ST_HEADER : ST_PAYLOAD;
                        end else begin
                            if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
                            state <= in_eop ? ST_IDLE : ST_DROP;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (in_valid) begin
                        if (slot_at_end) trunc  <= 1'b1;
                        else             offset <= offset + OFF_W'(1);
                        if (in_eop) state <= ST_HEADER;
                    end
                end
                ST_HEADER: state <= ST_IDLE;
                ST_DROP: begin
                    if (in_valid && in_eop) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dircc_mailbox_writer.sv
// Directed bench for dircc_mailbox_writer: logs every memory write and
// compares against hand-computed addresses, data and ring state.
module tb_dircc_mailbox_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_sop;
    logic        in_eop;
    logic        in_ready;
    logic [14:0] mem_address;
    logic        mem_chipselect;
    logic        mem_write;
    logic [15:0] mem_writedata;
    logic [1:0]  mem_byteenable;
    logic        mem_clken;
    logic        release_pulse;
    logic [2:0]  wr_slot;
    logic [2:0]  rd_slot;
    logic [3:0]  slots_used;
    logic [15:0] drop_count;
    logic        irq;

    dircc_mailbox_writer dut (
        .clk            (clk),
        .reset          (reset),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_sop         (in_sop),
        .in_eop         (in_eop),
        .in_ready       (in_ready),
        .mem_address    (mem_address),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .mem_byteenable (mem_byteenable),
        .mem_clken      (mem_clken),
        .release_pulse  (release_pulse),
        .wr_slot        (wr_slot),
        .rd_slot        (rd_slot),
        .slots_used     (slots_used),
        .drop_count     (drop_count),
        .irq            (irq)
    );

    always #5 clk = ~clk;

    logic [30:0] wlog[$];
    int          n_checks  = 0;
    int          n_fail    = 0;
    int          cs_err    = 0;
    int          stall_cnt = 0;
    logic        hdr_ready;

    always @(negedge clk) begin
        if (mem_write === 1'b1) wlog.push_back({mem_address, mem_writedata});
        if (mem_chipselect !== mem_write) cs_err++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] log_at(input int i);
        if (i < wlog.size()) return {1'b0, wlog[i]};
        return 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] wr(input logic [14:0] a, input logic [15:0] d);
        return {1'b0, a, d};
    endfunction

    function automatic int writes_to(input logic [14:0] a);
        int n = 0;
        foreach (wlog[i]) if (wlog[i][30:16] == a) n++;
        return n;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
        in_data = '0; release_pulse = 1'b0;
        tick; tick;
        reset = 1'b0;
    endtask

    // Beats are base, base+1, ...; one idle cycle follows to cover the header cycle.
    task automatic send_packet(input int n, input logic [15:0] base, input bit rel_on_hdr);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1; in_data = base + 16'(i);
            in_sop = (i == 0); in_eop = (i == n - 1);
            if (in_ready !== 1'b1) stall_cnt++;
            tick;
        end
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
        hdr_ready = in_ready;
        release_pulse = rel_on_hdr;
        tick;
        release_pulse = 1'b0;
    endtask

    task automatic pulse_release;
        release_pulse = 1'b1;
        tick;
        release_pulse = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset;
        check("rst_wr_slot",    32'(wr_slot), 0);
        check("rst_rd_slot",    32'(rd_slot), 0);
        check("rst_slots_used", 32'(slots_used), 0);
        check("rst_drop_count", 32'(drop_count), 0);
        check("rst_irq",        32'(irq), 0);
        check("rst_mem_write",  32'(mem_write), 0);
        check("rst_in_ready",   32'(in_ready), 1);
        check("const_be_clken", 32'({mem_byteenable, mem_clken}), 32'h7);

        // 3-beat packet into slot 0
        wlog.delete();
        send_packet(3, 16'hA001, 1'b0);
        check("p3_nwrites", wlog.size(), 4);
        check("p3_w0", log_at(0), wr(15'h4001, 16'hA001));
        check("p3_w1", log_at(1), wr(15'h4002, 16'hA002));
        check("p3_w2", log_at(2), wr(15'h4003, 16'hA003));
        check("p3_hdr", log_at(3), wr(15'h4000, 16'h0003));
        check("p3_hdr_ready", 32'(hdr_ready), 0);
        check("p3_wr_slot", 32'(wr_slot), 1);
        check("p3_slots_used", 32'(slots_used), 1);
        check("p3_irq_early", 32'(irq), 0);
        tick;
        check("p3_irq", 32'(irq), 1);

        // single-beat packet, then a truncated 70-beat packet into slot 1
        do_reset;
        wlog.delete();
        send_packet(1, 16'h1234, 1'b0);
        check("p1_nwrites", wlog.size(), 2);
        check("p1_w0", log_at(0), wr(15'h4001, 16'h1234));
        check("p1_hdr", log_at(1), wr(15'h4000, 16'h0001));

        wlog.delete();
        stall_cnt = 0;
        send_packet(70, 16'hB000, 1'b0);
        check("p70_nwrites", wlog.size(), 64);
        check("p70_first", log_at(0), wr(15'h4041, 16'hB000));
        check("p70_last", log_at(62), wr(15'h407F, 16'hB03E));
        check("p70_hdr", log_at(63), wr(15'h4040, 16'h803F));
        check("p70_stalls", stall_cnt, 0);
        check("p70_wr_slot", 32'(wr_slot), 2);

        // fill slots 2..7, then two packets hit a full ring
        for (int s = 2; s < 8; s++) send_packet(1, 16'h2000 + 16'(s), 1'b0);
        check("full_slots_used", 32'(slots_used), 8);
        check("full_wr_slot", 32'(wr_slot), 0);
        wlog.delete();
        send_packet(2, 16'hDEAD, 1'b0);
        send_packet(2, 16'hBEEF, 1'b0);
        check("drop_nwrites", wlog.size(), 0);
        check("drop_count", 32'(drop_count), 2);
        check("drop_slots_used", 32'(slots_used), 8);
        pulse_release;
        check("rel_slots_used", 32'(slots_used), 7);
        check("rel_rd_slot", 32'(rd_slot), 1);
        wlog.delete();
        send_packet(1, 16'h5555, 1'b0);
        check("wrap_w0", log_at(0), wr(15'h4001, 16'h5555));
        check("wrap_hdr", log_at(1), wr(15'h4000, 16'h0001));
        check("wrap_wr_slot", 32'(wr_slot), 1);
        check("wrap_slots_used", 32'(slots_used), 8);

        // release coinciding with a header commit, then release on an empty ring
        do_reset;
        for (int s = 0; s < 3; s++) send_packet(1, 16'h6000 + 16'(s), 1'b0);
        check("pre_used", 32'(slots_used), 3);
        send_packet(1, 16'h7000, 1'b1);
        check("co_slots_used", 32'(slots_used), 3);
        check("co_rd_slot", 32'(rd_slot), 1);
        check("co_wr_slot", 32'(wr_slot), 4);
        for (int r = 0; r < 3; r++) pulse_release;
        check("drain_used", 32'(slots_used), 0);
        pulse_release;
        check("empty_rel_used", 32'(slots_used), 0);
        check("empty_rel_rd", 32'(rd_slot), 4);
        tick;
        check("empty_irq", 32'(irq), 0);

        // reset during beat 2 of a 4-beat packet into slot 5
        send_packet(1, 16'h9000, 1'b0);
        tick;
        check("pre_rst_irq", 32'(irq), 1);
        wlog.delete();
        in_valid = 1'b1; in_data = 16'hC001; in_sop = 1'b1; in_eop = 1'b0;
        tick;
        in_data = 16'hC002; in_sop = 1'b0; reset = 1'b1;
        tick;
        reset = 1'b0; in_valid = 1'b0;
        check("mid_rst_wr_slot", 32'(wr_slot), 0);
        check("mid_rst_rd_slot", 32'(rd_slot), 0);
        check("mid_rst_used", 32'(slots_used), 0);
        check("mid_rst_irq", 32'(irq), 0);
        check("mid_rst_mem_write", 32'(mem_write), 0);
        in_valid = 1'b1; in_data = 16'hC003;
        tick;
        in_data = 16'hC004; in_eop = 1'b1;
        tick;
        in_valid = 1'b0; in_eop = 1'b0;
        tick;
        check("mid_rst_nwrites", wlog.size(), 2);
        check("mid_rst_no_hdr5", writes_to(15'h4140), 0);
        check("mid_rst_no_hdr0", writes_to(15'h4000), 0);
        wlog.delete();
        send_packet(2, 16'hD001, 1'b0);
        check("restart_w0", log_at(0), wr(15'h4001, 16'hD001));
        check("restart_w1", log_at(1), wr(15'h4002, 16'hD002));
        check("restart_hdr", log_at(2), wr(15'h4000, 16'h0002));
        check("restart_wr_slot", 32'(wr_slot), 1);

        check("chipselect_tracks_write", cs_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
